dds_param_scheduler: RTL and testbench

DDS_PARAM_SCHEDULER -- requirements
Module: dds_param_scheduler

---
 rtl/dds_sched_pkg.sv | 35 +++
 rtl/dds_cmd_fifo.sv | 53 +++++
 rtl/dds_param_scheduler.sv | 126 ++++++++++++
 tb/tb_dds_param_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sched_pkg.sv
// rtl/dds_sched_pkg.sv - command layout, field offsets and FSM state type for the DDS parameter scheduler
package dds_sched_pkg;

  localparam int CMD_W     = 160;
  localparam int EXEC_LSB  = 0;
  localparam int FREQ_LSB  = 64;
  localparam int PHASE_LSB = 112;
  localparam int AMP_LSB   = 126;
  localparam int AOFF_LSB  = 140;
  localparam int SYNC_BIT  = 154;
  localparam int RSVD_LSB  = 155;

  typedef struct packed {
    logic        sync;
    logic [13:0] amp_offset;
    logic [13:0] amp;
    logic [13:0] phase;
    logic [47:0] freq;
    logic [63:0] exec_time;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

  function automatic cmd_t unpack_cmd(input logic [RSVD_LSB-1:0] w);
    cmd_t c;
    c.exec_time  = w[EXEC_LSB  +: 64];
    c.freq       = w[FREQ_LSB  +: 48];
    c.phase      = w[PHASE_LSB +: 14];
    c.amp        = w[AMP_LSB   +: 14];
    c.amp_offset = w[AOFF_LSB  +: 14];
    c.sync       = w[SYNC_BIT];
    return c;
  endfunction

endpackage

// File: rtl/dds_cmd_fifo.sv
// rtl/dds_cmd_fifo.sv - first-word-fall-through command FIFO with occupancy count
module dds_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dds_param_scheduler.sv
// rtl/dds_param_scheduler.sv - applies queued DDS parameter sets when the free-running timestamp reaches their exec_time
module dds_param_scheduler
  import dds_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          run,
  input  logic [CMD_W-1:0]              s_axis_cmd_tdata,
  input  logic                          s_axis_cmd_tvalid,
  output logic                          s_axis_cmd_tready,
  output logic [63:0]                   timestamp,
  output logic [47:0]                   freq,
  output logic [13:0]                   phase,
  output logic [13:0]                   amp,
  output logic [13:0]                   amp_offset,
  output logic [63:0]                   time_offset,
  output logic                          cmd_applied,
  output logic                          late,
  output logic [15:0]                   late_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_t      state;
  state_t      state_nxt;
  cmd_t        cmd_in;
  cmd_t        head;
  cmd_t        hold;
  logic [63:0] ts_next;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        load_hold;
  logic        apply;
  logic        is_late;
  logic        cmd_avail;
  logic        ready_en;
  logic        unused_reserved;

  assign unused_reserved   = ^s_axis_cmd_tdata[CMD_W-1:RSVD_LSB];
  assign cmd_in            = unpack_cmd(s_axis_cmd_tdata[RSVD_LSB-1:0]);
  assign s_axis_cmd_tready = ready_en && !fifo_full;
  assign push              = s_axis_cmd_tvalid && s_axis_cmd_tready;
  assign ts_next           = timestamp + {63'd0, run};
  assign is_late           = hold.exec_time < ts_next;
  // A command landing this cycle counts as available so back-to-back commands keep two-cycle spacing.
  assign cmd_avail         = !fifo_empty || push;

  dds_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (cmd_in),
    .pop    (pop),
    .dout   (head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_avail) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_WAIT;
      ST_WAIT: if (apply) state_nxt = cmd_avail ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    load_hold = 1'b0;
    apply     = 1'b0;
    case (state)
      ST_LOAD: begin
        pop       = 1'b1;
        load_hold = 1'b1;
      end
      ST_WAIT: apply = (hold.exec_time <= ts_next);
      default: ;
    endcase
  end

  // Parameters load with ts_next so they appear together with timestamp == exec_time.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_en    <= 1'b0;
      timestamp   <= '0;
      hold        <= '0;
      freq        <= '0;
      phase       <= '0;
      amp         <= '0;
      amp_offset  <= '0;
      time_offset <= '0;
      cmd_applied <= 1'b0;
      late        <= 1'b0;
      late_count  <= '0;
    end else begin
      ready_en    <= 1'b1;
      timestamp   <= ts_next;
      cmd_applied <= apply;
      late        <= apply && is_late;
      if (load_hold) hold <= head;
      if (apply) begin
        freq       <= hold.freq;
        phase      <= hold.phase;
        amp        <= hold.amp;
        amp_offset <= hold.amp_offset;
        if (hold.sync) time_offset <= hold.exec_time;
        if (is_late && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dds_param_scheduler.sv
// tb/tb_dds_param_scheduler.sv - scoreboard bench for dds_param_scheduler
module tb_dds_param_scheduler;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         run = 1'b0;
  logic [159:0] s_axis_cmd_tdata = '0;
  logic         s_axis_cmd_tvalid = 1'b0;
  logic         s_axis_cmd_tready;
  logic [63:0]  timestamp;
  logic [47:0]  freq;
  logic [13:0]  phase;
  logic [13:0]  amp;
  logic [13:0]  amp_offset;
  logic [63:0]  time_offset;
  logic         cmd_applied;
  logic         late;
  logic [15:0]  late_count;
  logic [3:0]   fifo_level;

  always #5 clk = ~clk;

  dds_param_scheduler #(.FIFO_DEPTH(8)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .run               (run),
    .s_axis_cmd_tdata  (s_axis_cmd_tdata),
    .s_axis_cmd_tvalid (s_axis_cmd_tvalid),
    .s_axis_cmd_tready (s_axis_cmd_tready),
    .timestamp         (timestamp),
    .freq              (freq),
    .phase             (phase),
    .amp               (amp),
    .amp_offset        (amp_offset),
    .time_offset       (time_offset),
    .cmd_applied       (cmd_applied),
    .late              (late),
    .late_count        (late_count),
    .fifo_level        (fifo_level)
  );

  typedef struct {
    logic [63:0] et;
    logic [47:0] f;
    logic [13:0] ph;
    logic [13:0] am;
    logic [13:0] ao;
    logic        sy;
  } cmd_s;

  cmd_s        sb[$];
  logic [63:0] ts_m = '0;
  logic [63:0] tof_m = '0;
  logic [15:0] lc_m = '0;
  logic        rst_edge = 1'b1;
  bit          started = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_applied = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, required the awaited event", name);
  endtask

  // Reference timestamp: zero under reset, otherwise advances by run each edge.
  always @(posedge clk) begin
    rst_edge <= !resetn;
    if (!resetn) ts_m <= '0;
    else         ts_m <= ts_m + {63'd0, run};
  end

  always @(negedge clk) begin : monitor
    cmd_s e;
    logic exp_late;
    if (started) begin
      if (rst_edge) begin
        sb.delete();
        tof_m = '0;
        lc_m  = '0;
      end
      check("timestamp", timestamp, ts_m);
      if (cmd_applied) begin
        n_applied++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_apply: got cmd_applied=1 with nothing pending, required 0");
        end else begin
          e = sb.pop_front();
          exp_late = (e.et < ts_m);
          if (e.sy) tof_m = e.et;
          if (exp_late && lc_m != 16'hFFFF) lc_m = lc_m + 16'd1;
          check("apply_not_early", {63'd0, (e.et > ts_m)}, 64'd0);
          check("freq", freq, e.f);
          check("phase", phase, e.ph);
          check("amp", amp, e.am);
          check("amp_offset", amp_offset, e.ao);
          check("time_offset", time_offset, tof_m);
          check("late", late, exp_late);
          check("late_count", late_count, lc_m);
        end
      end else begin
        check("late_without_apply", late, 0);
      end
    end
  end

  task automatic push_cmd(input logic [63:0] et, input logic [47:0] f, input logic [13:0] ph,
                          input logic [13:0] am, input logic [13:0] ao, input logic sy,
                          input int bound, output bit ok);
    logic [4:0] rsv;
    rsv = 5'($urandom);
    s_axis_cmd_tdata  = {rsv, sy, ao, am, ph, f, et};
    s_axis_cmd_tvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      logic rdy;
      @(negedge clk);
      rdy = s_axis_cmd_tready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    s_axis_cmd_tvalid = 1'b0;
    if (ok) sb.push_back('{et, f, ph, am, ao, sy});
    else fail_bound("push_accept");
  endtask

  task automatic wait_ts(input logic [63:0] t, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      #1;
      if (timestamp == t) return;
    end
    fail_bound("wait_timestamp");
  endtask

  task automatic wait_apply(input int bound, output int n);
    n = 0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (cmd_applied) begin
        n = k;
        return;
      end
    end
    fail_bound("wait_apply");
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    fail_bound("wait_drain");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n;
    int          base_app;
    logic [63:0] base;

    repeat (3) @(posedge clk);
    #1 started = 1'b1;
    @(negedge clk);
    check("rst_tready", s_axis_cmd_tready, 0);
    check("rst_timestamp", timestamp, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_freq", freq, 0);
    check("rst_amp", amp, 0);
    check("rst_time_offset", time_offset, 0);
    check("rst_late_count", late_count, 0);
    check("rst_cmd_applied", cmd_applied, 0);

    // on-time apply
    @(posedge clk);
    #1 resetn = 1'b1;
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_reset", s_axis_cmd_tready, 1);
    wait_ts(64'd5, 20);
    push_cmd(64'd100, 48'h1000, 14'd0, 14'h2000, 14'd0, 1'b0, 10, ok);
    wait_apply(200, n);
    check("ontime_timestamp", timestamp, 64'd100);
    check("ontime_amp", amp, 14'h2000);
    check("ontime_late", late, 0);
    @(negedge clk);
    check("ontime_single_pulse", cmd_applied, 0);

    // late command
    do_reset();
    wait_ts(64'd50, 80);
    push_cmd(64'd3, 48'h55, 14'd1, 14'd2, 14'd3, 1'b0, 10, ok);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (cmd_applied) begin
        n = k;
        break;
      end
    end
    check("late_latency", n, 2);
    check("late_pulse", late, 1);
    check("late_count_one", late_count, 1);

    // equal exec_time pair
    base = ts_m + 64'd10;
    push_cmd(base, 48'd1, 14'd1, 14'd1, 14'd1, 1'b0, 10, ok);
    push_cmd(base, 48'd2, 14'd2, 14'd2, 14'd2, 1'b0, 10, ok);
    wait_apply(50, n);
    check("pair_first_late", late, 0);
    wait_apply(10, n);
    check("pair_spacing", n, 2);
    check("pair_second_late", late, 1);
    check("pair_late_count", late_count, 2);

    // FIFO fill and back-pressure
    @(posedge clk);
    #1 base = ts_m + 64'd300;
    for (int i = 0; i < 9; i++)
      push_cmd(base + 64'(i), 48'({$urandom, $urandom}), 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 2, ok);
    @(negedge clk);
    check("fill_level", fifo_level, 8);
    check("fill_tready_low", s_axis_cmd_tready, 0);
    base_app = n_applied;
    push_cmd(base + 64'd20, 48'hABC, 14'd7, 14'd8, 14'd9, 1'b0, 600, ok);
    check("fill_tenth_after_apply", {63'd0, (n_applied > base_app)}, 64'd1);
    wait_drain(700);

    // sync handling
    do_reset();
    push_cmd(64'h200, 48'h123, 14'd4, 14'd5, 14'd6, 1'b1, 10, ok);
    push_cmd(64'h208, 48'h456, 14'd7, 14'd8, 14'd9, 1'b0, 10, ok);
    wait_apply(700, n);
    check("sync_apply_offset", time_offset, 64'h200);
    wait_drain(100);
    check("sync0_keeps_offset", time_offset, 64'h200);

    // run=0 holds a pending command
    do_reset();
    push_cmd(64'd41, 48'h77, 14'd1, 14'd2, 14'd3, 1'b0, 10, ok);
    wait_ts(64'd40, 60);
    run = 1'b0;
    base_app = n_applied;
    repeat (10) @(posedge clk);
    #1;
    check("run0_no_apply", n_applied - base_app, 0);
    check("run0_ts_held", timestamp, 64'd40);
    run = 1'b1;
    wait_apply(10, n);
    check("run1_apply_ts", timestamp, 64'd41);

    // reset during WAIT flushes everything
    do_reset();
    for (int i = 0; i < 4; i++)
      push_cmd(64'd40 + 64'(i), 48'h99, 14'd1, 14'd1, 14'd1, 1'b1, 10, ok);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("flush_timestamp", timestamp, 0);
    check("flush_freq", freq, 0);
    check("flush_phase", phase, 0);
    check("flush_amp", amp, 0);
    check("flush_amp_offset", amp_offset, 0);
    check("flush_time_offset", time_offset, 0);
    check("flush_late_count", late_count, 0);
    check("flush_cmd_applied", cmd_applied, 0);
    check("flush_late", late, 0);
    check("flush_fifo_level", fifo_level, 0);
    check("flush_tready", s_axis_cmd_tready, 0);
    base_app = n_applied;
    @(negedge clk);
    check("flush_tready_release", s_axis_cmd_tready, 1);
    repeat (80) @(negedge clk);
    check("flush_no_stale_apply", n_applied - base_app, 0);

    // randomized traffic
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        run = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 run = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      push_cmd(ts_m + 64'($urandom_range(0, 14)) - 64'd4, 48'({$urandom, $urandom}),
               14'($urandom), 14'($urandom), 14'($urandom), 1'($urandom_range(0, 1)), 200, ok);
    end
    wait_drain(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
